// File: rtl/impulse_accumulator.sv
// impulse_accumulator: per-frame signed multiply-accumulate of impulse taps against delayed samples.
// Ports: clk, reset (sync, active-high); adc_clock frame strobe (asynchronous, synchronised here);
//   num_taps, impulse_valid/impulse_word, sample_valid/sample_data in; tap_ready, data_out, data_valid, overrun out.
module impulse_accumulator #(
  parameter int MAX_TAPS = 500
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        adc_clock,
  input  logic [10:0] num_taps,
  input  logic        impulse_valid,
  input  logic [15:0] impulse_word,
  input  logic        sample_valid,
  input  logic [15:0] sample_data,
  output logic        tap_ready,
  output logic [15:0] data_out,
  output logic        data_valid,
  output logic        overrun
);

  typedef enum logic [2:0] {IDLE, WAIT_TAP, WAIT_SAMPLE, MAC, DONE} state_t;

  localparam logic [10:0] MaxTaps = 11'(MAX_TAPS);

  state_t             state_q;
  logic               sync1_q, sync2_q, sync3_q;
  logic               restart_q;
  logic signed [31:0] acc_q;
  logic [10:0]        tap_cnt_q;
  logic [10:0]        taps_q;
  logic               neg_q;
  logic [7:0]         mult_q;
  logic [15:0]        sample_q;
  logic [15:0]        data_out_q;
  logic               data_valid_q;
  logic               overrun_q;

  logic               frame_edge;
  logic               mid_frame;
  logic               start_frame;
  logic               abort_frame;
  logic [10:0]        taps_clamped;
  logic signed [24:0] prod_full;
  logic signed [23:0] prod_mag;
  logic signed [23:0] prod;
  logic signed [32:0] sum_wide;
  logic signed [31:0] acc_d;
  logic signed [31:0] acc_shift;
  logic [15:0]        conv_out;

  // Offset fields of the impulse word belong to the delay line, not this block.
  logic unused_offsets;
  assign unused_offsets = ^impulse_word[15:9];

  always_comb begin
    frame_edge   = sync2_q & ~sync3_q;
    mid_frame    = (state_q == WAIT_TAP) || (state_q == WAIT_SAMPLE) || (state_q == MAC);
    // A queued restart (after an aborted frame) behaves exactly like a fresh edge.
    start_frame  = restart_q || (frame_edge && !mid_frame);
    abort_frame  = frame_edge && mid_frame;
    taps_clamped = (num_taps > MaxTaps) ? MaxTaps : num_taps;

    // Low 25 bits of the product are the same for signed and unsigned multiply, and
    // |sample * mult| <= 32768*255 fits in 24 signed bits, so truncation is exact.
    prod_full = $signed({{9{sample_q[15]}}, sample_q}) * $signed({17'd0, mult_q});
    prod_mag  = prod_full[23:0];
    prod      = neg_q ? -prod_mag : prod_mag;

    sum_wide = {{9{prod[23]}}, prod} + {acc_q[31], acc_q};
    if (sum_wide[32] != sum_wide[31]) begin
      acc_d = sum_wide[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
    end else begin
      acc_d = sum_wide[31:0];
    end

    acc_shift = acc_q >>> 8;
    if (acc_shift > 32'sd32767) begin
      conv_out = 16'h7FFF;
    end else if (acc_shift < -32'sd32768) begin
      conv_out = 16'h8000;
    end else begin
      conv_out = acc_shift[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      sync3_q      <= 1'b0;
      restart_q    <= 1'b0;
      acc_q        <= '0;
      tap_cnt_q    <= '0;
      taps_q       <= '0;
      neg_q        <= 1'b0;
      mult_q       <= '0;
      sample_q     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sync1_q      <= adc_clock;
      sync2_q      <= sync1_q;
      sync3_q      <= sync2_q;
      data_valid_q <= 1'b0;
      restart_q    <= 1'b0;

      if (abort_frame) begin
        // Flush the partial sum now; the new frame is latched on the following cycle.
        data_out_q   <= conv_out;
        data_valid_q <= 1'b1;
        overrun_q    <= 1'b1;
        restart_q    <= 1'b1;
        state_q      <= IDLE;
      end else if (start_frame) begin
        // An edge landing on DONE still delivers the finished frame's result.
        if (state_q == DONE) begin
          data_out_q   <= conv_out;
          data_valid_q <= 1'b1;
        end
        acc_q     <= '0;
        tap_cnt_q <= '0;
        taps_q    <= taps_clamped;
        state_q   <= (taps_clamped == 11'd0) ? DONE : WAIT_TAP;
      end else begin
        case (state_q)
          WAIT_TAP: begin
            if (impulse_valid) begin
              neg_q   <= impulse_word[8];
              mult_q  <= impulse_word[7:0];
              state_q <= WAIT_SAMPLE;
            end
          end
          WAIT_SAMPLE: begin
            if (sample_valid) begin
              sample_q <= sample_data;
              state_q  <= MAC;
            end
          end
          MAC: begin
            acc_q     <= acc_d;
            tap_cnt_q <= tap_cnt_q + 11'd1;
            state_q   <= ((tap_cnt_q + 11'd1) == taps_q) ? DONE : WAIT_TAP;
          end
          DONE: begin
            data_out_q   <= conv_out;
            data_valid_q <= 1'b1;
            state_q      <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign tap_ready  = (state_q == WAIT_TAP) || (state_q == WAIT_SAMPLE);
  assign data_out   = data_out_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule

// File: doc/impulse_accumulator.md
IMPULSE_ACCUMULATOR -- requirements
Module: impulse_accumulator

Interface
REQ-001 SHALL have parameter MAX_TAPS, default 500, the largest accepted tap count per frame; num_taps above it clamps to MAX_TAPS.
REQ-002 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port adc_clock  input  1  sample-rate clock; its rising edge starts a frame.
REQ-005 SHALL have port num_taps  input  11  impulse taps per frame, latched at frame start.
REQ-006 SHALL have port impulse_valid  input  1  impulse_word valid this cycle.
REQ-007 SHALL have port impulse_word  input  16  [15:13] top offset, [12:9] bottom offset, [8] negative, [7:0] unsigned multiplier.
REQ-008 SHALL have port sample_valid  input  1  sample_data valid this cycle.
REQ-009 SHALL have port sample_data  input  16  signed two's-complement delayed sample.
REQ-010 SHALL have port tap_ready  output  1  high in WAIT_TAP or WAIT_SAMPLE.
REQ-011 SHALL have port data_out  output  16  signed filtered output, held between frames.
REQ-012 SHALL have port data_valid  output  1  one-cycle pulse when data_out updates.
REQ-013 SHALL have port overrun  output  1  sticky; set when a frame is aborted; cleared only by reset.

Function
REQ-014 SHALL synchronise adc_clock through two flops, then detect a rising edge with a third flop; edge-to-frame-start latency is 3 clk cycles.
REQ-015 SHALL implement states IDLE, WAIT_TAP, WAIT_SAMPLE, MAC, DONE.
REQ-016 On frame start from any state: clear 32-bit accumulator, clear tap counter, latch min(num_taps, MAX_TAPS); go to DONE if the latched value is 0, else WAIT_TAP.
REQ-017 WAIT_TAP: on impulse_valid, register negative and multiplier and go to WAIT_SAMPLE; the offset fields are ignored by this block.
REQ-018 WAIT_SAMPLE: on sample_valid, register sample_data and go to MAC.
REQ-019 MAC (1 cycle): product = sample x {0,multiplier} as 24-bit signed; negate if negative; sign-extend to 32 bits; add to accumulator with signed saturation to 32 bits; increment tap counter.
REQ-020 After MAC: go to DONE if tap counter equals the latched count, else WAIT_TAP.
REQ-021 DONE (1 cycle): data_out = accumulator arithmetic-shifted right 8, saturated to [-32768, 32767]; pulse data_valid; go to IDLE.
REQ-022 Valid strobes outside their own state SHALL be ignored; a simultaneous impulse_valid and sample_valid in WAIT_TAP accepts only the impulse word.
REQ-023 A frame start before DONE SHALL first emit the partial accumulator through the DONE conversion (data_valid pulse) and set overrun; the new frame begins on the next cycle.
REQ-024 Multiplier 0 SHALL still count as a tap; a -32768 sample with multiplier 255 negated SHALL not wrap.
REQ-025 Per-tap throughput SHALL be at most 3 cycles with the strobes asserted back-to-back.

Reset
REQ-026 Reset SHALL force IDLE, accumulator 0, tap counter 0, data_out 0, data_valid 0, overrun 0, tap_ready 0, and all sync flops 0.
REQ-027 Reset asserted mid-frame SHALL discard the frame with no data_valid pulse; a frame edge coincident with reset SHALL be ignored.

Verification
REQ-028 num_taps=1, word 16'h00FF, sample 16'h4000 -> data_out 16'h3FC0, one data_valid pulse.
REQ-029 num_taps=2, taps (neg=0,mult=128, sample 1000) and (neg=1,mult=64, sample 1000) -> data_out 250.
REQ-030 num_taps=0 -> data_valid 4 cycles after the adc_clock rise, data_out 0, tap_ready never high.
REQ-031 num_taps=300, every tap mult=255 with sample 32767 -> data_out saturates to 32767; all-negative variant -> -32768.
REQ-032 Second adc_clock rise after 3 of 5 taps -> partial result output, overrun=1, new frame proceeds normally and overrun stays set.
REQ-033 Reset pulsed during WAIT_SAMPLE -> all outputs 0 next cycle, no data_valid, next frame correct.
